// File: rtl/param_integer_datapath.sv
// param_integer_datapath
// Parametrised integer datapath: register file (R0 hardwired to zero, write
// data bypassed to same-cycle reads), registered S/T operand latches, a
// single-cycle ALU with registered result and NZCV flags, an iterative
// multiply/divide unit loading HI/LO, and a Y-mux choosing the output and
// write-back value.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   D_En, D_Addr        register-file write enable / address (data = ALU_OUT)
//   S_Addr, T_Addr      register-file read addresses
//   DT, T_Sel           alternate T operand and its select (1: DT)
//   FS                  function select (0x1C..0x1F are multiply/divide)
//   md_start            request a multiply/divide for the MD code on FS
//   DY, PC_In           memory/I/O data (registered as D_in), program counter
//   Y_Sel               output mux: 0 HI, 1 LO, 2 ALU result, 3 D_in, 4-7 PC_In
//   N, Z, C, V          registered ALU flags
//   md_busy, md_done    MD unit running / one-cycle completion pulse
//   D_OUT               RT latch contents
//   ALU_OUT             Y-mux output, also the register-file write data
//
// MD handshake: md_start is accepted only while md_busy is low (this
// includes the md_done cycle); md_busy and md_done are registered.
module param_integer_datapath #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D_En,
    input  logic [AW-1:0]    D_Addr,
    input  logic [AW-1:0]    S_Addr,
    input  logic [AW-1:0]    T_Addr,
    input  logic [WIDTH-1:0] DT,
    input  logic             T_Sel,
    input  logic [4:0]       FS,
    input  logic             md_start,
    input  logic [WIDTH-1:0] DY,
    input  logic [WIDTH-1:0] PC_In,
    input  logic [2:0]       Y_Sel,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] D_OUT,
    output logic [WIDTH-1:0] ALU_OUT
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   ONE_X    = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [SW-1:0]    LAST_CNT = SW'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Register file with bypass
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] regs [NREGS];
    logic             wr_en;
    logic [WIDTH-1:0] s_read, t_read;

    assign wr_en = D_En && (D_Addr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[D_Addr] <= ALU_OUT;
        end
    end

    // A write to the address being read returns the value being written.
    always_comb begin
        s_read = (S_Addr == '0) ? '0 : regs[S_Addr];
        t_read = (T_Addr == '0) ? '0 : regs[T_Addr];
        if (wr_en && (D_Addr == S_Addr)) s_read = ALU_OUT;
        if (wr_en && (D_Addr == T_Addr)) t_read = ALU_OUT;
    end

    // ------------------------------------------------------------------
    // Operand latches and D_in
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rs, rt, d_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs   <= '0;
            rt   <= '0;
            d_in <= '0;
        end else begin
            rs   <= s_read;
            rt   <= T_Sel ? DT : t_read;
            d_in <= DY;
        end
    end

    assign D_OUT = rt;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic             is_md;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [SW-1:0]    shamt;

    assign is_md = (FS[4:2] == 3'b111);
    assign shamt = rt[SW-1:0];

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (FS)
            5'h00: alu_res = rs;
            5'h01: alu_res = rt;
            5'h02, 5'h03: begin
                sum     = {1'b0, rs} + {1'b0, rt};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (FS == 5'h02) && (rs[WIDTH-1] == rt[WIDTH-1])
                          && (alu_res[WIDTH-1] != rs[WIDTH-1]);
            end
            5'h04, 5'h05: begin
                // C is not-borrow: carry out of S + ~T + 1
                sum     = {1'b0, rs} + {1'b0, ~rt} + ONE_X;
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (FS == 5'h04) && (rs[WIDTH-1] != rt[WIDTH-1])
                          && (alu_res[WIDTH-1] != rs[WIDTH-1]);
            end
            5'h06: alu_res = ($signed(rs) < $signed(rt)) ? ONE : '0;
            5'h07: alu_res = (rs < rt) ? ONE : '0;
            5'h08: alu_res = rs & rt;
            5'h09: alu_res = rs | rt;
            5'h0A: alu_res = rs ^ rt;
            5'h0B: alu_res = ~(rs | rt);
            5'h0C: alu_res = rs << shamt;
            5'h0D: alu_res = rs >> shamt;
            5'h0E: alu_res = $unsigned($signed(rs) >>> shamt);
            5'h0F: begin
                sum     = {1'b0, rs} + ONE_X;
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = !rs[WIDTH-1] && alu_res[WIDTH-1];
            end
            5'h10: begin
                // S - 1 as S + all-ones; carry out is not-borrow
                sum     = {1'b0, rs} + {1'b0, {WIDTH{1'b1}}};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = rs[WIDTH-1] && !alu_res[WIDTH-1];
            end
            default: alu_res = '0;
        endcase
    end

    logic [WIDTH-1:0] result;

    // MD codes leave the result register and flags untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
            N <= 1'b0;
            Z <= 1'b0;
            C <= 1'b0;
            V <= 1'b0;
        end else if (!is_md) begin
            result <= alu_res;
            N <= alu_res[WIDTH-1];
            Z <= (alu_res == '0);
            C <= alu_c;
            V <= alu_v;
        end
    end

    // ------------------------------------------------------------------
    // Multiply/divide unit: FSM (three processes) + iteration datapath
    // ------------------------------------------------------------------
    typedef enum logic {MD_IDLE, MD_RUN} md_state_t;
    md_state_t md_state, md_next;

    logic          md_load, md_step, md_last;
    logic [SW-1:0] md_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) md_state <= MD_IDLE;
        else        md_state <= md_next;
    end

    always_comb begin
        md_next = md_state;
        case (md_state)
            MD_IDLE: if (md_start && is_md) md_next = MD_RUN;
            MD_RUN:  if (md_cnt == LAST_CNT) md_next = MD_IDLE;
            default: md_next = MD_IDLE;
        endcase
    end

    always_comb begin
        md_busy = (md_state == MD_RUN);
        md_load = (md_state == MD_IDLE) && md_start && is_md;
        md_step = (md_state == MD_RUN);
        md_last = (md_state == MD_RUN) && (md_cnt == LAST_CNT);
    end

    // Signed operations run unsigned on magnitudes; signs are fixed up at the end.
    logic             md_div, neg_q, neg_r, md_dvz;
    logic [WIDTH-1:0] md_a;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi;      // partial product high / partial remainder
    logic [WIDTH-1:0] acc_lo;      // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0] md_dividend; // original dividend for divide-by-zero
    logic [WIDTH-1:0] hi, lo;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        a_neg = FS[1] && rs[WIDTH-1];
        b_neg = FS[1] && rt[WIDTH-1];
        mag_a = a_neg ? -rs : rs;
        mag_b = b_neg ? -rt : rt;
    end

    logic [WIDTH:0]   msum, trial;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fin_hi, fin_lo;

    always_comb begin
        msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_a} : '0);
        trial  = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, md_a};
        nxt_hi = '0;
        nxt_lo = '0;
        prod   = '0;
        fin_hi = '0;
        fin_lo = '0;
        if (!md_div) begin
            // shift-add: add multiplicand if LSB set, then shift {hi,lo} right
            nxt_hi = msum[WIDTH:1];
            nxt_lo = {msum[0], acc_lo[WIDTH-1:1]};
            prod   = {nxt_hi, nxt_lo};
            if (neg_q) prod = -prod;
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else begin
            // restoring: keep the subtraction only when it does not go negative
            if (!trial[WIDTH]) begin
                nxt_hi = trial[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
            if (md_dvz) begin
                fin_hi = md_dividend;
                fin_lo = '1;
            end else begin
                fin_hi = neg_r ? -nxt_hi : nxt_hi;
                fin_lo = neg_q ? -nxt_lo : nxt_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt      <= '0;
            md_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            md_dvz      <= 1'b0;
            md_a        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            md_dividend <= '0;
            hi          <= '0;
            lo          <= '0;
            md_done     <= 1'b0;
        end else begin
            md_done <= md_last;
            if (md_load) begin
                md_cnt      <= '0;
                md_div      <= FS[0];
                neg_q       <= a_neg ^ b_neg;
                neg_r       <= a_neg;
                md_dvz      <= (rt == '0);
                md_dividend <= rs;
                acc_hi      <= '0;
                if (FS[0]) begin
                    md_a   <= mag_b;
                    acc_lo <= mag_a;
                end else begin
                    md_a   <= mag_a;
                    acc_lo <= mag_b;
                end
            end else if (md_step) begin
                md_cnt <= md_cnt + 1'b1;
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
            end
            if (md_last) begin
                hi <= fin_hi;
                lo <= fin_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // Y-mux
    // ------------------------------------------------------------------
    always_comb begin
        case (Y_Sel)
            3'd0:    ALU_OUT = hi;
            3'd1:    ALU_OUT = lo;
            3'd2:    ALU_OUT = result;
            3'd3:    ALU_OUT = d_in;
            default: ALU_OUT = PC_In;
        endcase
    end

endmodule

// File: tb/tb_param_integer_datapath.sv
module tb_param_integer_datapath;

    localparam int W = 32;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // 32-bit / 32-register instance
    logic         D_En = 0, T_Sel = 0, md_start = 0;
    logic [4:0]   D_Addr = 0, S_Addr = 0, T_Addr = 0, FS = 0;
    logic [W-1:0] DT = 0, DY = 0, PC_In = 32'h0000_1000;
    logic [2:0]   Y_Sel = 3'd2;
    logic         N, Z, C, V, md_busy, md_done;
    logic [W-1:0] D_OUT, ALU_OUT;

    param_integer_datapath #(.WIDTH(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .D_En(D_En), .D_Addr(D_Addr),
        .S_Addr(S_Addr), .T_Addr(T_Addr), .DT(DT), .T_Sel(T_Sel), .FS(FS),
        .md_start(md_start), .DY(DY), .PC_In(PC_In), .Y_Sel(Y_Sel),
        .N(N), .Z(Z), .C(C), .V(V), .md_busy(md_busy), .md_done(md_done),
        .D_OUT(D_OUT), .ALU_OUT(ALU_OUT)
    );

    // 16-bit / 8-register instance
    logic         u_D_En = 0, u_T_Sel = 0, u_md_start = 0;
    logic [2:0]   u_D_Addr = 0, u_S_Addr = 0, u_T_Addr = 0;
    logic [4:0]   u_FS = 0;
    logic [15:0]  u_DT = 0, u_DY = 0, u_PC_In = 16'h0040;
    logic [2:0]   u_Y_Sel = 3'd2;
    logic         u_N, u_Z, u_C, u_V, u_md_busy, u_md_done;
    logic [15:0]  u_D_OUT, u_ALU_OUT;

    param_integer_datapath #(.WIDTH(16), .NREGS(8)) dut16 (
        .clk(clk), .reset(reset), .D_En(u_D_En), .D_Addr(u_D_Addr),
        .S_Addr(u_S_Addr), .T_Addr(u_T_Addr), .DT(u_DT), .T_Sel(u_T_Sel),
        .FS(u_FS), .md_start(u_md_start), .DY(u_DY), .PC_In(u_PC_In),
        .Y_Sel(u_Y_Sel), .N(u_N), .Z(u_Z), .C(u_C), .V(u_V),
        .md_busy(u_md_busy), .md_done(u_md_done), .D_OUT(u_D_OUT),
        .ALU_OUT(u_ALU_OUT)
    );

    // scoreboard
    // sel: 0 ALU_OUT, 1 D_OUT, 2 {N,Z,C,V}, 3 md_busy, 4 md_done,
    //      5 16-bit ALU_OUT, 6 16-bit md_busy, 7 16-bit md_done
    typedef struct packed {
        logic [2:0]   sel;
        logic [W-1:0] val;
    } exp_t;

    exp_t         exp_q[$];
    string        name_q[$];
    logic [W-1:0] md_q[$];      // expected LO, checked on md_done with Y_Sel=1
    int           n_vec = 0;
    int           n_bad = 0;

    function automatic logic [W-1:0] pick(input logic [2:0] sel);
        case (sel)
            3'd0:    return ALU_OUT;
            3'd1:    return D_OUT;
            3'd2:    return {28'd0, N, Z, C, V};
            3'd3:    return {31'd0, md_busy};
            3'd4:    return {31'd0, md_done};
            3'd5:    return {16'd0, u_ALU_OUT};
            3'd6:    return {31'd0, u_md_busy};
            default: return {31'd0, u_md_done};
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t         e;
        string        nm;
        logic [W-1:0] act;
        logic [W-1:0] lo_exp;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = pick(e.sel);
            n_vec++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", nm, act, e.val);
            end
        end
        if (md_done === 1'b1) begin
            n_vec++;
            if (md_q.size() == 0) begin
                n_bad++;
                $display("FAIL md_done: got unexpected pulse expected none");
            end else begin
                lo_exp = md_q.pop_front();
                if (ALU_OUT !== lo_exp) begin
                    n_bad++;
                    $display("FAIL md_lo: got %h expected %h", ALU_OUT, lo_exp);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [2:0] sel, input logic [W-1:0] val, input string nm);
        exp_q.push_back('{sel: sel, val: val});
        name_q.push_back(nm);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [W-1:0] v);
        DY = v;
        step();
        Y_Sel = 3'd3; D_En = 1'b1; D_Addr = a;
        step();
        D_En = 1'b0; Y_Sel = 3'd2;
    endtask

    task automatic alu_vec(input logic [4:0] fs, input logic [W-1:0] res, input logic [3:0] nzcv);
        FS = fs;
        step();
        chk(3'd0, res, $sformatf("alu fs=%02h", fs));
        chk(3'd2, {28'd0, nzcv}, $sformatf("flags fs=%02h", fs));
    endtask

    // latch S register / DT, run one MD op to completion, check LO and HI
    task automatic md_run(input logic [4:0] s, input logic [W-1:0] dt, input logic [4:0] fs,
                          input logic [W-1:0] lo, input logic [W-1:0] hi, input string nm);
        S_Addr = s; T_Sel = 1'b1; DT = dt; Y_Sel = 3'd1;
        step();
        FS = fs; md_start = 1'b1;
        md_q.push_back(lo);
        step();
        md_start = 1'b0;
        repeat (W) step();
        step();
        Y_Sel = 3'd0;
        chk(3'd0, hi, {nm, " hi"});
        step();
    endtask

    initial begin
        // reset state
        step();
        step();
        chk(3'd0, 32'h0, "reset result");
        chk(3'd2, 32'h0, "reset flags");
        chk(3'd1, 32'h0, "reset d_out");
        chk(3'd3, 32'h0, "reset busy");
        step();
        reset = 1'b1;
        step();

        // register write through D_in and read back
        write_reg(5'd5, 32'h1234_5678);
        S_Addr = 5'd5; T_Addr = 5'd5; T_Sel = 1'b0; FS = 5'h00;
        step();
        chk(3'd1, 32'h1234_5678, "r5 d_out");
        step();
        chk(3'd0, 32'h1234_5678, "r5 pass s");

        // R0 ignores writes
        write_reg(5'd0, 32'hFFFF_FFFF);
        S_Addr = 5'd0; T_Addr = 5'd0; FS = 5'h00;
        step();
        chk(3'd1, 32'h0, "r0 d_out");
        step();
        chk(3'd0, 32'h0, "r0 pass s");

        // ALU vectors with RS=0x7FFFFFFF, RT=1
        write_reg(5'd1, 32'h7FFF_FFFF);
        S_Addr = 5'd1; T_Sel = 1'b1; DT = 32'h1;
        step();
        alu_vec(5'h02, 32'h8000_0000, 4'b1001);
        alu_vec(5'h03, 32'h8000_0000, 4'b1000);
        alu_vec(5'h04, 32'h7FFF_FFFE, 4'b0010);
        alu_vec(5'h06, 32'h0000_0000, 4'b0100);
        alu_vec(5'h0C, 32'hFFFF_FFFE, 4'b1000);
        alu_vec(5'h0E, 32'h3FFF_FFFF, 4'b0000);
        alu_vec(5'h0B, 32'h8000_0000, 4'b1000);
        alu_vec(5'h0F, 32'h8000_0000, 4'b1001);
        alu_vec(5'h1D, 32'h8000_0000, 4'b1001);   // MD code, no start: hold
        alu_vec(5'h12, 32'h0000_0000, 4'b0100);
        alu_vec(5'h0A, 32'h7FFF_FFFE, 4'b0000);

        // SUBU 5 - 5
        write_reg(5'd2, 32'h5);
        S_Addr = 5'd2; T_Sel = 1'b1; DT = 32'h5;
        step();
        alu_vec(5'h05, 32'h0, 4'b0110);

        // bypass onto S
        FS = 5'h00;
        DY = 32'hA5A5_A5A5;
        step();
        Y_Sel = 3'd3; D_En = 1'b1; D_Addr = 5'd7; S_Addr = 5'd7;
        step();
        D_En = 1'b0; Y_Sel = 3'd2;
        step();
        chk(3'd0, 32'hA5A5_A5A5, "bypass s");

        // bypass onto T
        DY = 32'h5A5A_5A5A;
        step();
        Y_Sel = 3'd3; D_En = 1'b1; D_Addr = 5'd9; T_Addr = 5'd9; T_Sel = 1'b0;
        step();
        D_En = 1'b0; Y_Sel = 3'd2;
        chk(3'd1, 32'h5A5A_5A5A, "bypass t");
        step();

        // MUL -3 x 7 with a start while busy that must be ignored
        write_reg(5'd3, 32'hFFFF_FFFD);
        S_Addr = 5'd3; T_Sel = 1'b1; DT = 32'h7; Y_Sel = 3'd1;
        step();
        FS = 5'h1E; md_start = 1'b1;
        md_q.push_back(32'hFFFF_FFEB);
        step();
        md_start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            if (i == 1 || i == 10 || i == W) chk(3'd3, 32'h1, $sformatf("mul busy c%0d", i));
            md_start = (i == 10);
            if (i == 10) begin
                FS = 5'h1F; DT = 32'd100;
            end
            step();
        end
        chk(3'd3, 32'h0, "mul busy end");
        chk(3'd4, 32'h1, "mul done");
        step();
        Y_Sel = 3'd0;
        chk(3'd4, 32'h0, "mul done pulse");
        chk(3'd0, 32'hFFFF_FFFF, "mul hi");
        step();

        // DIV -7 / 2, then DIVU 9 / 0 started in the md_done cycle
        write_reg(5'd4, 32'hFFFF_FFF9);
        write_reg(5'd6, 32'h9);
        S_Addr = 5'd4; T_Sel = 1'b1; DT = 32'h2; Y_Sel = 3'd1;
        step();
        FS = 5'h1F; md_start = 1'b1;
        md_q.push_back(32'hFFFF_FFFD);
        step();
        md_start = 1'b0; S_Addr = 5'd6; DT = 32'h0;
        repeat (W) step();
        FS = 5'h1D; md_start = 1'b1;
        md_q.push_back(32'hFFFF_FFFF);
        step();
        md_start = 1'b0; Y_Sel = 3'd0;
        chk(3'd0, 32'hFFFF_FFFF, "div hi");
        chk(3'd3, 32'h1, "divu back-to-back busy");
        step();
        Y_Sel = 3'd1;
        repeat (W - 1) step();
        step();
        Y_Sel = 3'd0;
        chk(3'd0, 32'h9, "divu0 hi");
        step();

        // signed min / -1 and signed divide by zero
        write_reg(5'd10, 32'h8000_0000);
        md_run(5'd10, 32'hFFFF_FFFF, 5'h1F, 32'h8000_0000, 32'h0, "min/-1");
        md_run(5'd4, 32'h0, 5'h1F, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "div0 signed");

        // reset in the middle of an MD operation
        S_Addr = 5'd3; T_Sel = 1'b1; DT = 32'h7; Y_Sel = 3'd1;
        step();
        FS = 5'h1E; md_start = 1'b1;
        step();
        md_start = 1'b0;
        repeat (9) step();
        reset = 1'b0; Y_Sel = 3'd0;
        chk(3'd3, 32'h0, "abort busy");
        chk(3'd0, 32'h0, "abort hi");
        step();
        Y_Sel = 3'd1;
        chk(3'd0, 32'h0, "abort lo");
        chk(3'd4, 32'h0, "abort done");
        step();
        reset = 1'b1; FS = 5'h00;
        step();

        // 16-bit instance: MULU 0xFFFF x 0xFFFF
        u_DY = 16'hFFFF;
        step();
        u_Y_Sel = 3'd3; u_D_En = 1'b1; u_D_Addr = 3'd3;
        step();
        u_D_En = 1'b0; u_S_Addr = 3'd3; u_T_Sel = 1'b1; u_DT = 16'hFFFF; u_Y_Sel = 3'd1;
        step();
        u_FS = 5'h1C; u_md_start = 1'b1;
        step();
        u_md_start = 1'b0;
        chk(3'd6, 32'h1, "w16 busy");
        repeat (16) step();
        chk(3'd7, 32'h1, "w16 done");
        chk(3'd5, 32'h0000_0001, "w16 lo");
        step();
        u_Y_Sel = 3'd0;
        chk(3'd5, 32'h0000_FFFE, "w16 hi");
        step();
        u_Y_Sel = 3'd4;
        chk(3'd5, 32'h0000_0040, "w16 pc");
        step();

        @(negedge clk);
        #1;
        while (md_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL md_missing: got no md_done expected lo %h", md_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
